// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the Wishbone N-slave interconnect.
// Holds the FSM state encoding, bus data width and slave-count limit.
package wb_ic_pkg;

    localparam int DATA_W     = 32;
    localparam int MAX_SLAVES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        ERROR   = 2'd2,
        RELEASE = 2'd3
    } ic_state_t;

endpackage

// File: rtl/wb_ic_timeout.sv
// Stall watchdog for the interconnect: counts consecutive stalled cycles.
// Fires on the cycle whose edge would bring the count up to TIMEOUT.
module wb_ic_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count stalled cycles; any ack or dropped strobe restarts the count
    always_ff @(posedge clk) begin
        if (rst || !stall) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // expire on the stalled cycle that completes TIMEOUT stalls
    always_comb begin
        expired = stall && (count == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/wishbone_nslave_interconnect.sv
// One-master to N-slave Wishbone interconnect with registered slave select.
// Define WB_IC_TIMEOUT_EN to enable the stalled-access watchdog.
module wishbone_nslave_interconnect
    import wb_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 24,
    parameter int SEL_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [DATA_W-1:0]            m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic                         m_int_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    output logic [NUM_SLAVES-1:0]        s_we_o,
    output logic [DATA_W-1:0]            s_adr_o,
    output logic [DATA_W-1:0]            s_dat_o,
    input  logic [DATA_W*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES-1:0]        s_int_i
);

    localparam logic [DATA_W-1:0] FIELD_ONES =
        (SEL_WIDTH >= DATA_W) ? '1 : ((DATA_W'(1) << SEL_WIDTH) - DATA_W'(1));
    localparam logic [DATA_W-1:0] SEL_MASK = FIELD_ONES << SEL_LSB;

    ic_state_t            state;
    ic_state_t            state_nxt;
    logic [SEL_WIDTH-1:0] sel;
    logic [SEL_WIDTH-1:0] field;
    logic                 start;
    logic                 ack_sel;
    logic [DATA_W-1:0]    dat_sel;
    logic                 stall;
    logic                 timeout_hit;

    assign field   = m_adr_i[SEL_LSB +: SEL_WIDTH];
    assign start   = m_cyc_i && m_stb_i;
    assign s_adr_o = m_adr_i & ~SEL_MASK;
    assign s_dat_o = m_dat_i;
    assign stall   = (state == ACTIVE) && m_stb_i && !ack_sel;

`ifdef WB_IC_TIMEOUT_EN
    wb_ic_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // state register and slave-select latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sel <= field;
            end
        end
    end

    // registered interrupt aggregation
    always_ff @(posedge clk) begin
        if (rst) begin
            m_int_o <= 1'b0;
        end else begin
            m_int_o <= |s_int_i;
        end
    end

    // pick the selected slave's ack and read data
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = '0;
        for (int k = 0; k < NUM_SLAVES && k < MAX_SLAVES; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                ack_sel = s_ack_i[k];
                dat_sel = s_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // next state and per-state bus outputs
    always_comb begin
        state_nxt = state;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        s_we_o    = '0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_dat_o   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (int'(field) < NUM_SLAVES) begin
                        state_nxt = ACTIVE;
                    end else begin
                        state_nxt = ERROR;
                    end
                end
            end
            ACTIVE: begin
                for (int k = 0; k < NUM_SLAVES && k < MAX_SLAVES; k++) begin
                    if (sel == SEL_WIDTH'(k)) begin
                        s_cyc_o[k] = m_cyc_i;
                        s_stb_o[k] = m_stb_i;
                        s_we_o[k]  = m_we_i;
                    end
                end
                m_ack_o = ack_sel;
                m_dat_o = dat_sel;
                if (!m_cyc_i) begin
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ERROR;
                end
            end
            ERROR: begin
                m_err_o   = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!m_cyc_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_nslave_interconnect.sv
// Directed-vector bench for wishbone_nslave_interconnect (4 slaves, TIMEOUT=8).
// Build with WB_IC_TIMEOUT_EN defined to exercise the watchdog path.
module tb_wishbone_nslave_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_cyc_i;
    logic         m_stb_i;
    logic         m_we_i;
    logic [31:0]  m_adr_i;
    logic [31:0]  m_dat_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o;
    logic         m_err_o;
    logic         m_int_o;
    logic [3:0]   s_cyc_o;
    logic [3:0]   s_stb_o;
    logic [3:0]   s_we_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i;
    logic [3:0]   s_int_i;

    int n_vec = 0;
    int n_bad = 0;

    wishbone_nslave_interconnect #(
        .NUM_SLAVES (4),
        .SEL_LSB    (24),
        .SEL_WIDTH  (8),
        .TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_int_o (m_int_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_int_i (s_int_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_bus();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_ack_i = '0;
        s_int_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst     = 1'b1;
        s_dat_i = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h11111111};
        idle_bus();
        step();
        step();
        settle();
        chk("rst_stb", 32'(s_stb_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_ack", 32'(m_ack_o), 32'h0);
        chk("rst_err", 32'(m_err_o), 32'h0);
        chk("rst_int", 32'(m_int_o), 32'h0);
        chk("rst_dat", m_dat_o, 32'h0);
        rst = 1'b0;
        step();

        // read slave 1
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_adr_i = 32'h01000010;
        settle();
        chk("rd_pre_stb", 32'(s_stb_o), 32'h0);
        chk("rd_adr", s_adr_o, 32'h00000010);
        step();
        settle();
        chk("rd_stb", 32'(s_stb_o), 32'h2);
        chk("rd_cyc", 32'(s_cyc_o), 32'h2);
        chk("rd_we", 32'(s_we_o), 32'h0);
        chk("rd_dat", m_dat_o, 32'hCAFEF00D);
        chk("rd_noack", 32'(m_ack_o), 32'h0);
        s_ack_i = 4'b0001;
        settle();
        chk("rd_foreign_ack", 32'(m_ack_o), 32'h0);
        s_ack_i = 4'b0010;
        settle();
        chk("rd_ack", 32'(m_ack_o), 32'h1);
        step();
        m_stb_i = 1'b0;
        s_ack_i = '0;
        settle();
        chk("rd_ack_drop", 32'(m_ack_o), 32'h0);
        m_cyc_i = 1'b0;
        step();
        settle();
        chk("rd_idle_dat", m_dat_o, 32'h0);

        // write slave 3
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b1;
        m_adr_i = 32'h03000004;
        m_dat_i = 32'h12345678;
        step();
        settle();
        chk("wr_stb", 32'(s_stb_o), 32'h8);
        chk("wr_we", 32'(s_we_o), 32'h8);
        chk("wr_sdat", s_dat_o, 32'h12345678);
        chk("wr_adr", s_adr_o, 32'h00000004);
        s_ack_i = 4'b1000;
        settle();
        chk("wr_ack", 32'(m_ack_o), 32'h1);
        step();
        idle_bus();
        step();
        // a fresh access must decode from IDLE with one cycle of delay
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_adr_i = 32'h00000020;
        settle();
        chk("wr_back_idle", 32'(s_stb_o), 32'h0);
        step();
        settle();
        chk("wr_next_stb", 32'(s_stb_o), 32'h1);
        idle_bus();
        step();

        // out-of-range slave
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_adr_i = 32'h07000000;
        settle();
        chk("er_pre_err", 32'(m_err_o), 32'h0);
        step();
        settle();
        chk("er_err", 32'(m_err_o), 32'h1);
        chk("er_stb", 32'(s_stb_o), 32'h0);
        step();
        settle();
        chk("er_err_once", 32'(m_err_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("er_hold_err", 32'(m_err_o), 32'h0);
        end
        // still in RELEASE: a new strobe with cyc high must not decode
        m_adr_i = 32'h00000000;
        step();
        settle();
        chk("er_hold_stb", 32'(s_stb_o), 32'h0);
        idle_bus();
        step();
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_adr_i = 32'h02000000;
        step();
        settle();
        chk("er_released", 32'(s_stb_o), 32'h4);

`ifdef WB_IC_TIMEOUT_EN
        // slave 2 never acks: 8 stalled cycles then error
        for (int i = 0; i < 7; i++) begin
            step();
            settle();
            chk("to_wait_err", 32'(m_err_o), 32'h0);
            chk("to_wait_stb", 32'(s_stb_o), 32'h4);
        end
        step();
        settle();
        chk("to_err", 32'(m_err_o), 32'h1);
        chk("to_stb_drop", 32'(s_stb_o), 32'h0);
        step();
        settle();
        chk("to_err_once", 32'(m_err_o), 32'h0);
`else
        // without the watchdog the access waits indefinitely
        for (int i = 0; i < 20; i++) begin
            step();
        end
        settle();
        chk("nt_err", 32'(m_err_o), 32'h0);
        chk("nt_stb", 32'(s_stb_o), 32'h4);
`endif
        idle_bus();
        step();

        // interrupt aggregation
        s_int_i = 4'b0100;
        settle();
        chk("int_pre", 32'(m_int_o), 32'h0);
        step();
        s_int_i = '0;
        settle();
        chk("int_set", 32'(m_int_o), 32'h1);
        step();
        settle();
        chk("int_clr", 32'(m_int_o), 32'h0);

        // reset during an active access
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_adr_i = 32'h01000000;
        step();
        s_ack_i = 4'b0010;
        settle();
        chk("mr_active", 32'(s_stb_o), 32'h2);
        rst = 1'b1;
        step();
        settle();
        chk("mr_stb", 32'(s_stb_o), 32'h0);
        chk("mr_cyc", 32'(s_cyc_o), 32'h0);
        chk("mr_ack", 32'(m_ack_o), 32'h0);
        chk("mr_dat", m_dat_o, 32'h0);
        chk("mr_err", 32'(m_err_o), 32'h0);
        idle_bus();
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
